// File: rtl/two_neuron_top.sv
// rtl/two_neuron_top.sv - two-stage fixed-point neuron: 8->1 hidden MAC neuron, 1->8 output lanes
// Q6.10 datapath; 11-cycle free-running LOAD/MAC x8/ACT/OUT loop with registered outputs.
module two_neuron_top #(
  parameter logic [127:0] W1 = {8{16'h0400}},
  parameter logic [15:0]  B1 = 16'h0000,
  parameter logic [127:0] W2 = {16'h0400, 16'h0380, 16'h0300, 16'h0280,
                                16'h0200, 16'h0180, 16'h0100, 16'h0080},
  parameter logic [127:0] B2 = 128'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] X,
  output logic [127:0] Y
);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_ACT, S_OUT} state_t;

  localparam logic signed [35:0] B1_EXT = {{20{B1[15]}}, B1};

  state_t              state_q, state_d;
  logic [2:0]          lane_q, lane_d;
  logic [127:0]        xreg_q, xreg_d;
  logic signed [35:0]  acc_q, acc_d;
  logic [15:0]         h_q, h_d;
  logic [127:0]        y_q, y_d;

  logic signed [15:0]  mac_w, mac_x;
  logic signed [31:0]  mac_prod;
  logic signed [35:0]  act_s;
  logic [127:0]        y_out;

  // Clamp to the signed 16-bit range, then ReLU: result is always in [0, 0x7FFF].
  function automatic logic [15:0] sat_relu(input logic signed [35:0] v);
    if (v < 36'sd0)           return 16'h0000;
    else if (v > 36'sd32767)  return 16'h7FFF;
    else                      return v[15:0];
  endfunction

  assign mac_w    = W1[{lane_q, 4'b0000} +: 16];
  assign mac_x    = xreg_q[{lane_q, 4'b0000} +: 16];
  assign mac_prod = mac_w * mac_x;
  assign act_s    = (acc_q + (B1_EXT <<< 10)) >>> 10;

  for (genvar j = 0; j < 8; j++) begin : g_out
    localparam logic signed [35:0] W2_EXT = {{20{W2[16*j+15]}}, W2[16*j +: 16]};
    localparam logic signed [35:0] B2_EXT = {{20{B2[16*j+15]}}, B2[16*j +: 16]};
    logic signed [35:0] h_ext;
    logic signed [35:0] lane_v;
    assign h_ext  = {20'b0, h_q};
    assign lane_v = ((W2_EXT * h_ext) >>> 10) + B2_EXT;
    assign y_out[16*j +: 16] = sat_relu(lane_v);
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    xreg_d  = xreg_q;
    acc_d   = acc_q;
    h_d     = h_q;
    y_d     = y_q;
    case (state_q)
      S_LOAD: begin
        xreg_d  = X;
        acc_d   = '0;
        lane_d  = 3'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d  = acc_q + mac_prod;
        lane_d = lane_q + 3'd1;
        if (lane_q == 3'd7) state_d = S_ACT;
      end
      S_ACT: begin
        h_d     = sat_relu(act_s);
        state_d = S_OUT;
      end
      S_OUT: begin
        y_d     = y_out;
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      lane_q  <= 3'd0;
      xreg_q  <= '0;
      acc_q   <= '0;
      h_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      xreg_q  <= xreg_d;
      acc_q   <= acc_d;
      h_q     <= h_d;
      y_q     <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_two_neuron_top.sv
// tb/tb_two_neuron_top.sv - scoreboard bench for two_neuron_top
module tb_two_neuron_top;

  localparam logic [127:0] X_ONES  = {8{16'h0400}};
  localparam logic [127:0] Y_ONES  = {16'h2000, 16'h1C00, 16'h1800, 16'h1400,
                                      16'h1000, 16'h0C00, 16'h0800, 16'h0400};
  localparam logic [127:0] X_LANE6 = {16'h0400, 16'h0000, {6{16'h0400}}};
  localparam logic [127:0] Y_LANE6 = {16'h1C00, 16'h1880, 16'h1500, 16'h1180,
                                      16'h0E00, 16'h0A80, 16'h0700, 16'h0380};
  localparam logic [127:0] X_NEG   = {8{16'hFC00}};
  localparam logic [127:0] X_SAT   = {8{16'h7FFF}};
  localparam logic [127:0] Y_SAT   = {16'h7FFF, 16'h6FFF, 16'h5FFF, 16'h4FFF,
                                      16'h3FFF, 16'h2FFF, 16'h1FFF, 16'h0FFF};
  localparam logic [127:0] X_MIX   = {16'h0100, 16'h0100, 16'h0100, 16'h0100,
                                      16'h0000, 16'h0200, 16'hFC00, 16'h0800};
  localparam logic [127:0] Y_MIX   = {16'h0A00, 16'h08C0, 16'h0780, 16'h0640,
                                      16'h0500, 16'h03C0, 16'h0280, 16'h0140};

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] X;
  logic [127:0] Y;

  int           edge_cnt;
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_exp = '0;

  two_neuron_top dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  always #5 clk = ~clk;

  // Edges since reset release; outputs are due when this is a nonzero multiple of 11.
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: Y=%h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      last_exp = '0;
    end else if (edge_cnt > 0 && edge_cnt % 11 == 0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL update @edge %0d: Y=%h but no expected value queued", edge_cnt, Y);
      end else begin
        last_exp = exp_q.pop_front();
        check("update", Y, last_exp);
      end
    end else begin
      check("hold", Y, last_exp);
    end
  end

  task automatic wait_phase(input int p);
    do @(negedge clk); while (edge_cnt % 11 != p);
  endtask

  task automatic apply(input logic [127:0] x, input logic [127:0] y);
    wait_phase(0);
    X = x;
    #1 exp_q.push_back(y);
  endtask

  initial begin
    reset = 1'b0;
    X     = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
    repeat (2) @(negedge clk);
    check("reset_hold", Y, 128'h0);
    X = X_ONES;
    @(negedge clk);
    reset = 1'b1;
    #1 exp_q.push_back(Y_ONES);

    // Mid-loop change must not disturb the loop in flight.
    wait_phase(5);
    X = X_LANE6;
    wait_phase(0);
    #1 exp_q.push_back(Y_LANE6);

    apply(X_NEG,  128'h0);
    apply(X_SAT,  Y_SAT);
    apply(X_MIX,  Y_MIX);
    apply(X_ONES, Y_ONES);

    wait_phase(5);
    #2 reset = 1'b0;
    #1 check("reset_mid", Y, 128'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 exp_q.push_back(Y_ONES);
    wait_phase(0);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
